hz_meter: RTL and testbench

HZ_METER -- requirements
Module: hz_meter

---
 rtl/hz_meter.sv | 187 ++++++++++++++++++
 tb/tb_hz_meter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hz_meter.sv
// rtl/hz_meter.sv - gated rising-edge frequency meter; optional period measurement under HZ_METER_PERIOD_EN
module hz_meter #(
    parameter logic [31:0] c_GATE = 32'd100000000
) (
    input  logic        i_CLK,
    input  logic        i_RST_N,
    input  logic        i_EN,
    input  logic        i_SIG,
    output logic [31:0] o_Freq,
    output logic        o_Valid,
    output logic        o_NoSig,
    output logic [31:0] o_Period,
    output logic        o_PValid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        GATE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;
    logic        rise;
    logic        flush_q, flush_d;
    logic [31:0] gate_q, gate_d;
    logic [31:0] edge_q, edge_d;
    logic [31:0] freq_q, freq_d;
    logic        valid_q, valid_d;
    logic        nosig_q, nosig_d;
    logic [31:0] edge_sum;

    // Two-stage synchronizer followed by an edge-detect stage
    always_comb begin
        sync1_d = i_SIG;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        rise    = sync2_q & ~prev_q;
    end

    // Synchronizer and edge-detect registers
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // Measurement FSM: idle, two flush cycles to clear stale sync data, then back-to-back gate windows
    always_comb begin
        state_d  = state_q;
        flush_d  = flush_q;
        gate_d   = gate_q;
        edge_d   = edge_q;
        freq_d   = freq_q;
        nosig_d  = nosig_q;
        valid_d  = 1'b0;
        // A rise on the terminal cycle belongs to the closing window
        edge_sum = edge_q + {31'd0, rise};
        case (state_q)
            IDLE: begin
                flush_d = 1'b0;
                gate_d  = 32'd0;
                edge_d  = 32'd0;
                if (i_EN) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                gate_d = 32'd0;
                edge_d = 32'd0;
                if (!i_EN) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                end else if (flush_q) begin
                    state_d = GATE;
                    flush_d = 1'b0;
                end else begin
                    flush_d = 1'b1;
                end
            end
            GATE: begin
                if (!i_EN) begin
                    state_d = IDLE;
                    gate_d  = 32'd0;
                    edge_d  = 32'd0;
                end else if (gate_q == c_GATE - 32'd1) begin
                    freq_d  = edge_sum;
                    nosig_d = (edge_sum == 32'd0);
                    valid_d = 1'b1;
                    gate_d  = 32'd0;
                    edge_d  = 32'd0;
                end else begin
                    gate_d = gate_q + 32'd1;
                    edge_d = edge_sum;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, counter and result registers
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            gate_q  <= 32'd0;
            edge_q  <= 32'd0;
            freq_q  <= 32'd0;
            valid_q <= 1'b0;
            nosig_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            freq_q  <= freq_d;
            valid_q <= valid_d;
            nosig_q <= nosig_d;
        end
    end

    assign o_Freq  = freq_q;
    assign o_Valid = valid_q;
    assign o_NoSig = nosig_q;

`ifdef HZ_METER_PERIOD_EN
    logic [31:0] pcnt_q, pcnt_d;
    logic [31:0] period_q, period_d;
    logic        armed_q, armed_d;
    logic        pvalid_q, pvalid_d;
    logic [31:0] pcnt_inc;

    // Period counter: cycles since last rise, first rise in GATE only arms, disarmed while idle
    always_comb begin
        pcnt_inc = (pcnt_q == 32'hFFFF_FFFF) ? pcnt_q : pcnt_q + 32'd1;
        pcnt_d   = pcnt_q;
        period_d = period_q;
        armed_d  = armed_q;
        pvalid_d = 1'b0;
        if (state_q == IDLE) begin
            pcnt_d  = 32'd0;
            armed_d = 1'b0;
        end else if ((state_q == GATE) && i_EN && rise) begin
            if (armed_q) begin
                period_d = pcnt_inc;
                pvalid_d = 1'b1;
            end
            armed_d = 1'b1;
            pcnt_d  = 32'd0;
        end else begin
            pcnt_d = pcnt_inc;
        end
    end

    // Period registers
    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            pcnt_q   <= 32'd0;
            period_q <= 32'd0;
            armed_q  <= 1'b0;
            pvalid_q <= 1'b0;
        end else begin
            pcnt_q   <= pcnt_d;
            period_q <= period_d;
            armed_q  <= armed_d;
            pvalid_q <= pvalid_d;
        end
    end

    assign o_Period = period_q;
    assign o_PValid = pvalid_q;
`else
    assign o_Period = 32'd0;
    assign o_PValid = 1'b0;
`endif

endmodule

// File: tb/tb_hz_meter.sv
// tb/tb_hz_meter.sv - self-checking bench for hz_meter against an edge-timeline reference model
module tb_hz_meter;

    localparam int G = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sig;
    logic [31:0] o_freq;
    logic        o_valid;
    logic        o_nosig;
    logic [31:0] o_period;
    logic        o_pvalid;

    always #5 clk = ~clk;

    hz_meter #(.c_GATE(32'd100)) dut (
        .i_CLK    (clk),
        .i_RST_N  (rst_n),
        .i_EN     (en),
        .i_SIG    (sig),
        .o_Freq   (o_freq),
        .o_Valid  (o_valid),
        .o_NoSig  (o_nosig),
        .o_Period (o_period),
        .o_PValid (o_pvalid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Edge index and per-edge history of the sampled signal (forced low around resets)
    int n = 0;
    bit hist [0:16383];

    // Reference model state
    bit          active = 1'b0;
    bit          armed  = 1'b0;
    int          start_e = 0;
    int          acc = 0;
    int          last_rise = 0;
    logic [31:0] exp_freq = 32'd0;
    logic [31:0] exp_period = 32'd0;
    bit          exp_valid = 1'b0;
    bit          exp_nosig = 1'b0;
    bit          exp_pvalid = 1'b0;

    // Directed bookkeeping
    int dut_sum = 0;
    int vcount = 0;
    int last_v = 0;
    int phase = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %0d expected %0d", tag, n, got, exp);
        end
    endtask

    task automatic tick();
        bit rise;
        @(posedge clk);
        n++;
        if (!rst_n) begin
            hist[n] = 1'b0;
            hist[n-1] = 1'b0;
            hist[n-2] = 1'b0;
        end else begin
            hist[n] = sig;
        end
        rise = (n >= 3) && hist[n-2] && !hist[n-3];

        exp_valid  = 1'b0;
        exp_pvalid = 1'b0;
        if (!rst_n) begin
            active     = 1'b0;
            armed      = 1'b0;
            exp_freq   = 32'd0;
            exp_nosig  = 1'b0;
            exp_period = 32'd0;
        end else if (!active) begin
            if (en) begin
                active  = 1'b1;
                start_e = n;
                acc     = 0;
                armed   = 1'b0;
            end
        end else if (!en) begin
            active = 1'b0;
            armed  = 1'b0;
        end else if (n >= start_e + 3) begin
            if (rise) begin
                acc++;
`ifdef HZ_METER_PERIOD_EN
                if (armed) begin
                    exp_period = n - last_rise;
                    exp_pvalid = 1'b1;
                end
                armed     = 1'b1;
                last_rise = n;
`endif
            end
            if ((n - start_e - 2) % G == 0) begin
                exp_freq  = acc;
                exp_nosig = (acc == 0);
                exp_valid = 1'b1;
                acc       = 0;
            end
        end

        #1;
        chk("freq", o_freq, exp_freq);
        chk("valid", o_valid, exp_valid);
        chk("nosig", o_nosig, exp_nosig);
        chk("period", o_period, exp_period);
        chk("pvalid", o_pvalid, exp_pvalid);

        if (o_valid) begin
            dut_sum += o_freq;
            vcount++;
            if (phase == 2 && vcount >= 2) chk("freq10", o_freq, 32'd10);
            if (phase == 3 && vcount >= 2) chk("nosig_hi", o_nosig, 1'b1);
            if ((phase == 2 || phase == 3) && last_v != 0) chk("vgap", n - last_v, G);
            last_v = n;
        end
    endtask

    initial begin
        int e0;
        int lat;
        int bound;

        // Reset state
        rst_n = 1'b0;
        en    = 1'b0;
        sig   = 1'b0;
        repeat (3) tick();
        chk("rst_freq", o_freq, 32'd0);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_nosig", o_nosig, 1'b0);
        chk("rst_period", o_period, 32'd0);
        chk("rst_pvalid", o_pvalid, 1'b0);

        // Square wave, period 10
        phase  = 2;
        vcount = 0;
        last_v = 0;
        rst_n  = 1'b1;
        en     = 1'b1;
        bound  = 0;
        while (vcount < 5 && bound < 800) begin
            sig = ((n + 1) / 5) % 2;
            tick();
            bound++;
        end
        chk("p2_windows", vcount, 5);

        // Drop enable 50 cycles into a window
        repeat (49) begin
            sig = ((n + 1) / 5) % 2;
            tick();
        end
        phase = 0;
        en    = 1'b0;
        repeat (150) begin
            sig = ((n + 1) / 5) % 2;
            tick();
        end
        chk("hold10", o_freq, 32'd10);
        chk("hold_nosig", o_nosig, 1'b0);

        // Signal stuck high
        phase  = 3;
        vcount = 0;
        last_v = 0;
        sig    = 1'b1;
        en     = 1'b1;
        repeat (420) tick();
        chk("p3_windows", vcount, 4);

        // One-cycle reset mid-window, then latency from first enabled edge
        phase = 0;
        repeat (30) begin
            sig = ((n + 1) / 5) % 2;
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("rstmid_freq", o_freq, 32'd0);
        chk("rstmid_nosig", o_nosig, 1'b0);
        rst_n = 1'b1;
        e0    = n + 1;
        lat   = -1;
        for (int i = 0; i < 300; i++) begin
            sig = ((n + 1) / 5) % 2;
            tick();
            if (o_valid) begin
                lat = n - e0;
                break;
            end
        end
        chk("rst_lat", lat, 102);

        // Rises landing exactly on the terminal gate cycle of five windows
        en = 1'b0;
        sig = 1'b0;
        repeat (2) tick();
        en      = 1'b1;
        e0      = n + 1;
        dut_sum = 0;
        while (n < e0 + 2 + 5 * G) begin
            sig = ((n + 1 - e0) >= G) && (((n + 1 - e0) % G) < 5);
            tick();
        end
        chk("sum5", dut_sum, 5);
        chk("term_freq", o_freq, 32'd1);

        // Randomized signal, enable and reset activity
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) sig = ~sig;
            if (en) begin
                if ($urandom_range(0, 299) == 0) en = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                en = 1'b1;
            end
            rst_n = ($urandom_range(0, 799) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
